keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad, debounces presses, and queues one command code per completed key press. The block sits directly upstream of the calculator CPU. It drives the CPU's `in_cmd` input and consumes its `in_ack` handshake. A small FIFO absorbs keystrokes while the CPU is busy evaluating.

## Interface
- `SCAN_DIV`, 4: clock cycles each row is driven; minimum 3, to allow for the column synchronizer.
- `DEBOUNCE`, 3: consecutive identical samples required to accept a press or a release; minimum 1.
- `FIFO_DEPTH`, 4: number of queued key codes; must be a power of two, at least 2.
- `IC_W`, 5: width of the `in_cmd` bus.

Ports:
- `Clock`, input, 1: the single clock; all state changes on the rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `kb_row`, output, 4: row drive, active-low one-hot.
- `kb_col`, input, 4: column sense, active-low. Pulled up externally and asynchronous to `Clock`.
- `in_ack`, input, 1: the CPU consumes the current `in_cmd` at this edge.
- `in_cmd`, output, IC_W: code at the FIFO head, or 0 when the FIFO is empty.
- `drop`, output, 1: one-cycle pulse when an accepted key is discarded because the FIFO is full.

## Operation
- `kb_col` passes through a 2-flop synchronizer; all decisions use the synchronized value `col_s`.
- A dwell counter runs 0 to `SCAN_DIV-1`. The sample edge is the edge at which the counter equals `SCAN_DIV-1`. The counter wraps to 0 after the sample edge.
- A sample is "single" when exactly one bit of `col_s` is 0, and "idle" when `col_s` is 4'hF.
- Key code is {1'b1, row[1:0], col[1:0]}; row 0 is `kb_row`=4'b1110 and col 0 is `kb_col`[0]. Codes are therefore 5'h10 through 5'h1F, and 0 is reserved for "no command".

FSM states:
- SCAN: advances `kb_row` one row (0 to 3, wrapping to 0) at each sample edge.
  - On a single sample, go to PRESS with the row held, the column captured, and press count = 1.
  - A sample with two or more low columns is treated as no key, and scanning continues.
- PRESS: the row is held.
  - A single sample on the captured column increments the count.
  - When the count reaches `DEBOUNCE`, push the code and go to HELD.
  - Any other sample returns to SCAN with the row advanced.
  - With `DEBOUNCE`=1, the push happens on the same edge that enters PRESS.
- HELD: the row is held.
  - An idle sample increments the release count; any non-idle sample clears it.
  - When the release count reaches `DEBOUNCE`, return to SCAN with the row advanced.
  - No further codes are produced for this key. There is no auto-repeat.

FIFO rules:
- `in_cmd` shows the head entry while the FIFO is non-empty, and 0 otherwise.
- A pop occurs on any edge where `in_ack`=1 and the FIFO is non-empty. `in_ack` while empty is ignored.
- A push occurs when the FIFO is not full. If full, a simultaneous pop makes room, so push and pop both occur.
- If full with no pop, the code is discarded and `drop`=1 for the following cycle.
- Push and pop on the same edge leave the occupancy unchanged.

## Timing
- Reset values:
  - `kb_row`=4'b1110
  - `in_cmd`=0
  - `drop`=0
  - FIFO empty, state SCAN, all counters 0, synchronizer flops at 4'hF.
- Asserting `Reset` mid-operation clears everything immediately, including any queued codes.
- Press latency: a pushed code appears on `in_cmd` one cycle after the push edge when the FIFO was empty.
- Pop latency: after a pop edge, the next entry (or 0) is visible in the following cycle. The CPU samples `in_cmd` and asserts `in_ack` in the same cycle.
- `in_cmd` is fully registered and never changes except on a push into an empty FIFO, a pop, or reset.
- The `kb_row` change and the sample occur on the same edge, so each row gets `SCAN_DIV` cycles of settling time.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=3, with edges counted from 1 after reset release.
- Key held (row 2, col 1) from reset, no ack -> `in_cmd`=5'h19 from cycle 21 and held steady; `kb_row` stays 4'b1011 while the key is held.
- Key bounces (col 1 toggles every 3 cycles for 40 cycles, then released) -> `in_cmd` stays 0 and the FSM never reaches HELD.
- Five distinct presses (each a 40-cycle press followed by 40 cycles idle), no ack -> first four codes queued in order, fifth gives a `drop` pulse. Four acks then return 5'h10, 5'h11, 5'h12, 5'h13 and `in_cmd`=0.
- FIFO full, and `in_ack` asserted on the same edge as the fifth push -> no `drop`; occupancy stays 4 and the fifth code is last in order.
- Two keys in the same row pressed together -> no code produced; scanning continues across all rows.
- `Reset` asserted while in HELD with 2 codes queued -> `in_cmd`=0 and `kb_row`=4'b1110 immediately. After release, the still-held key produces exactly one new code.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Command handshake between the keypad scanner and the calculator CPU.
// Ports: in_cmd (queued key code, 0 = none), in_ack (CPU consumes in_cmd), drop (key discarded).
// master = scanner side, slave = CPU side.
interface keypad_scanner_if #(
    parameter int IC_W = 5
);
    logic [IC_W-1:0] in_cmd;
    logic            in_ack;
    logic            drop;

    modport master (output in_cmd, output drop, input in_ack);
    modport slave  (input in_cmd, input drop, output in_ack);
endinterface

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces presses and queues one code per press.
// Latency: a push into an empty queue shows on in_cmd next cycle; a pop shows the next entry next cycle.
// Backpressure: FIFO_DEPTH-entry queue; a key accepted while full and not popped is dropped with a drop pulse.
// Ports: Clock, Reset (async active-low), kb_row (active-low row drive), kb_col (async column sense),
//        cmd (in_cmd / in_ack / drop handshake to the CPU).
module keypad_scanner #(
    parameter int SCAN_DIV   = 4,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int IC_W       = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic [3:0]       kb_row,
    input  logic [3:0]       kb_col,
    keypad_scanner_if.master cmd
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {SCAN, PRESS, HELD} state_t;

    logic [3:0]    col_m, col_s;
    logic [DW-1:0] dwell;
    logic          sample;
    state_t        state, state_nx;
    logic [1:0]    row_idx, row_nx;
    logic [1:0]    col_idx, col_nx;
    logic [CW-1:0] deb_cnt, deb_nx;
    logic          push_req;
    logic [4:0]    push_dat;
    logic [3:0]    col_n;
    logic          single, idle;
    logic [1:0]    col_enc;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nx;
    logic [NW-1:0] count, count_nx;
    logic          full, empty, pop, push, drop_nx;
    logic [4:0]    cmd_q, cmd_nx;
    logic          drop_q;

    assign kb_row     = ~(4'b0001 << row_idx);
    assign cmd.in_cmd = IC_W'(cmd_q);
    assign cmd.drop   = drop_q;

    assign sample = (dwell == DW'(SCAN_DIV - 1));
    assign col_n  = ~col_s;
    assign single = (col_n != 4'd0) && ((col_n & (col_n - 4'd1)) == 4'd0);
    assign idle   = (col_s == 4'hF);

    always_comb begin
        col_enc = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (col_n[i]) col_enc = 2'(i);
        end
    end

    // Row is only held while a key is being qualified or held; every
    // exit back to SCAN moves on to the next row.
    always_comb begin
        state_nx = state;
        row_nx   = row_idx;
        col_nx   = col_idx;
        deb_nx   = deb_cnt;
        push_req = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (single) begin
                        col_nx = col_enc;
                        if (DEBOUNCE == 1) begin
                            push_req = 1'b1;
                            state_nx = HELD;
                            deb_nx   = '0;
                        end else begin
                            state_nx = PRESS;
                            deb_nx   = CW'(1);
                        end
                    end else begin
                        row_nx = row_idx + 2'd1;
                    end
                end
                PRESS: begin
                    if (single && col_enc == col_idx) begin
                        if (deb_cnt == CW'(DEBOUNCE - 1)) begin
                            push_req = 1'b1;
                            state_nx = HELD;
                            deb_nx   = '0;
                        end else begin
                            deb_nx = deb_cnt + 1'b1;
                        end
                    end else begin
                        state_nx = SCAN;
                        row_nx   = row_idx + 2'd1;
                        deb_nx   = '0;
                    end
                end
                HELD: begin
                    if (idle) begin
                        if (deb_cnt == CW'(DEBOUNCE - 1)) begin
                            state_nx = SCAN;
                            row_nx   = row_idx + 2'd1;
                            deb_nx   = '0;
                        end else begin
                            deb_nx = deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_nx = '0;
                    end
                end
                default: begin
                    state_nx = SCAN;
                    deb_nx   = '0;
                end
            endcase
        end
    end

    // col_nx is the freshly captured column on the SCAN edge (DEBOUNCE=1 case)
    // and the held column otherwise.
    assign push_dat = {1'b1, row_idx, col_nx};

    assign full     = (count == NW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = cmd.in_ack && !empty;
    assign push     = push_req && (!full || pop);
    assign drop_nx  = push_req && full && !pop;
    assign count_nx = count + NW'(push) - NW'(pop);
    assign rd_nx    = rd_ptr + AW'(pop);

    // in_cmd is registered: forward the incoming code when it becomes the
    // new head (queue empty after this edge's pop), otherwise read the array.
    always_comb begin
        if (push && count == NW'(pop)) begin
            cmd_nx = push_dat;
        end else if (count_nx == '0) begin
            cmd_nx = 5'd0;
        end else begin
            cmd_nx = mem[rd_nx];
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            col_m   <= 4'hF;
            col_s   <= 4'hF;
            dwell   <= '0;
            state   <= SCAN;
            row_idx <= 2'd0;
            col_idx <= 2'd0;
            deb_cnt <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            cmd_q   <= 5'd0;
            drop_q  <= 1'b0;
        end else begin
            col_m   <= kb_col;
            col_s   <= col_m;
            dwell   <= sample ? '0 : dwell + 1'b1;
            state   <= state_nx;
            row_idx <= row_nx;
            col_idx <= col_nx;
            deb_cnt <= deb_nx;
            rd_ptr  <= rd_nx;
            wr_ptr  <= wr_ptr + AW'(push);
            count   <= count_nx;
            cmd_q   <= cmd_nx;
            drop_q  <= drop_nx;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model driven from kb_row, queue-based expected command stream.
// Directed scenarios for timing, bounce, overflow, simultaneous keys and reset, then random presses/acks.
// All checks go through chk(); ends with one summary line.
module tb_keypad_scanner;
    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE   = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int IC_W       = 5;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  kb_row;
    logic [3:0]  kb_col;
    logic [15:0] key_mask = '0;   // bit 4*row+col set = key pressed
    int          cyc;
    int          n_cmp = 0;
    int          n_err = 0;
    int          drop_cnt = 0;
    logic [4:0]  q[$];            // expected queue contents, head first

    keypad_scanner_if #(.IC_W(IC_W)) cmd ();

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH), .IC_W(IC_W)
    ) dut (
        .Clock(Clock), .Reset(Reset), .kb_row(kb_row), .kb_col(kb_col), .cmd(cmd)
    );

    always #5 Clock = ~Clock;

    // edges since reset release: after edge n, cyc == n
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge Clock) begin
        if (Reset && cmd.drop) drop_cnt <= drop_cnt + 1;
    end

    // passive keypad: a pressed key shorts its row line to its column line
    always_comb begin
        kb_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!kb_row[r]) kb_col = kb_col & ~key_mask[r*4 +: 4];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] head();
        return (q.size() > 0) ? q[0] : 5'd0;
    endfunction

    function automatic logic [3:0] row_pat(input int r);
        logic [3:0] v;
        v = 4'b0001;
        v = v << r;
        return ~v;
    endfunction

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        cmd.in_ack = 1'b0;
        #1;
        chk("rst_row", kb_row, 4'b1110);
        chk("rst_cmd", cmd.in_cmd, 0);
        chk("rst_drop", cmd.drop, 0);
        q.delete();
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    // Press key (r,c) just after a sample edge, then follow the scan: the code
    // is pushed on the DEBOUNCE-th consecutive sample edge that drives row r.
    // Optionally ack on exactly that edge.
    task automatic press(input int r, input int c, input bit ack_push);
        int         hits = 0;
        bit         done = 0;
        logic [4:0] code;
        logic       exp_drop;
        code = 5'(16 + 4*r + c);
        do @(negedge Clock); while (cyc % SCAN_DIV != 0);
        key_mask[4*r + c] = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if ((cyc + 1) % SCAN_DIV == 0) begin
                if (kb_row == row_pat(r)) hits++;
                else                      hits = 0;
                if (hits == DEBOUNCE) begin
                    cmd.in_ack = ack_push;
                    done = 1;
                end
            end
            @(negedge Clock);
            cmd.in_ack = 1'b0;
        end
        chk("push_seen", done, 1);
        if (done) begin
            if (ack_push && q.size() > 0) void'(q.pop_front());
            exp_drop = (q.size() >= FIFO_DEPTH);
            if (!exp_drop) q.push_back(code);
            chk("push_cmd", cmd.in_cmd, head());
            chk("push_drop", cmd.drop, exp_drop);
        end
    endtask

    task automatic hold_release();
        int n;
        n = $urandom_range(30, 5);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            chk("hold_cmd", cmd.in_cmd, head());
            chk("hold_drop", cmd.drop, 0);
        end
        key_mask = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            chk("idle_cmd", cmd.in_cmd, head());
        end
    endtask

    task automatic do_ack();
        chk("ack_pre", cmd.in_cmd, head());
        cmd.in_ack = 1'b1;
        @(negedge Clock);
        cmd.in_ack = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        chk("ack_post", cmd.in_cmd, head());
    endtask

    initial begin
        int         d0;
        logic [3:0] seen;
        cmd.in_ack = 1'b0;

        // Key row 2 / col 1 held from reset: code at cycle 21, row held
        key_mask = '0;
        key_mask[9] = 1'b1;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clock);
            chk("t1_cmd", cmd.in_cmd, (n >= 20) ? 5'h19 : 5'h00);
            if (n >= 8) chk("t1_row", kb_row, 4'b1011);
        end
        q.push_back(5'h19);
        hold_release();
        do_ack();

        // Bouncing contact: col 1 toggles every 3 cycles, never accepted
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) key_mask[9] = ~key_mask[9];
            @(negedge Clock);
            chk("t2_cmd", cmd.in_cmd, 0);
        end
        key_mask = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            chk("t2_idle", cmd.in_cmd, 0);
        end

        // Five presses without ack: four queued, fifth dropped
        do_reset();
        d0 = drop_cnt;
        for (int k = 0; k < 5; k++) begin
            press(k / 4, k % 4, 1'b0);
            hold_release();
        end
        chk("t3_drops", drop_cnt - d0, 1);
        chk("t3_head", cmd.in_cmd, 5'h10);
        for (int k = 0; k < 4; k++) do_ack();
        chk("t3_empty", cmd.in_cmd, 0);

        // Full queue with ack on the fifth push edge: no drop
        do_reset();
        d0 = drop_cnt;
        for (int k = 0; k < 4; k++) begin
            press(0, k, 1'b0);
            hold_release();
        end
        press(1, 0, 1'b1);
        hold_release();
        chk("t4_drops", drop_cnt - d0, 0);
        chk("t4_head", cmd.in_cmd, 5'h11);
        for (int k = 0; k < 4; k++) do_ack();
        chk("t4_empty", cmd.in_cmd, 0);

        // Two keys in one row: ignored, scan keeps walking all rows
        do_reset();
        key_mask[4] = 1'b1;
        key_mask[6] = 1'b1;
        seen = 4'h0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            seen = seen | ~kb_row;
            chk("t5_cmd", cmd.in_cmd, 0);
        end
        chk("t5_rows", seen, 4'hF);
        key_mask = '0;

        // Reset while a key is held with two codes queued
        do_reset();
        press(3, 3, 1'b0);
        hold_release();
        press(2, 2, 1'b0);
        repeat (5) @(negedge Clock);
        do_reset();
        for (int i = 0; i < 100; i++) @(negedge Clock);
        q.push_back(5'h1A);
        chk("t6_cmd", cmd.in_cmd, 5'h1A);
        do_ack();
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            chk("t6_once", cmd.in_cmd, 0);
        end
        key_mask = '0;
        repeat (40) @(negedge Clock);

        // Random keys, random ack on push edge, random acks between presses
        do_reset();
        for (int k = 0; k < 12; k++) begin
            press($urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)));
            hold_release();
            for (int a = $urandom_range(2, 0); a > 0; a--) do_ack();
        end
        while (q.size() > 0) do_ack();
        chk("rnd_empty", cmd.in_cmd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
